// File: rtl/class_pkg.sv
// Shared types and default widths for the classifier value-memory path.
package class_pkg;

  localparam int unsigned NUM_CAND          = 4;
  localparam int unsigned DEFAULT_VT_AWIDTH = 15;
  localparam int unsigned DEFAULT_KEY_LEN   = 276;

  typedef enum logic [1:0] {
    StIdle,
    StLkup,
    StHost
  } class_vmem_arb_state_e;

endpackage

// File: rtl/class_vmem_rd_ret.sv
// Host read-return tracker: valid shift register and capture of the memory read data.
module class_vmem_rd_ret
  import class_pkg::*;
#(
  parameter int unsigned KEY_LEN = DEFAULT_KEY_LEN,
  parameter int unsigned RD_LAT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_issue,
  input  logic [KEY_LEN-1:0] val_mem_dout_q,
  output logic               host_rdata_vld,
  output logic [KEY_LEN-1:0] host_rdata
);

  logic [RD_LAT:0]    vld_q;
  logic [KEY_LEN-1:0] rdata_q;

  // Stage RD_LAT-1 is the cycle the memory data is valid; the last stage presents it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      rdata_q <= '0;
    end else begin
      vld_q <= {vld_q[RD_LAT-1:0], rd_issue};
      if (vld_q[RD_LAT-1]) begin
        rdata_q <= val_mem_dout_q;
      end
    end
  end

  assign host_rdata_vld = vld_q[RD_LAT];
  assign host_rdata     = rdata_q;

endmodule

// File: rtl/class_vmem_arb.sv
// Value-memory sequencer/arbiter: four-slot lookup bursts plus single-cycle host accesses.
// Defining CLASS_VMEM_ARB_HOST_FAIRNESS_EN bounds host starvation.
module class_vmem_arb
  import class_pkg::*;
#(
  parameter int unsigned KEY_LEN       = DEFAULT_KEY_LEN,
  parameter int unsigned VT_AWIDTH     = DEFAULT_VT_AWIDTH,
  parameter int unsigned RD_LAT        = 4,
  parameter int unsigned HOST_MAX_WAIT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lk_vld,
  output logic                          lk_rdy,
  input  logic                          lk_err,
  input  logic [NUM_CAND-1:0]           lk_hit_mask,
  input  logic [NUM_CAND*VT_AWIDTH-1:0] lk_ptr,
  input  logic [KEY_LEN-1:0]            lk_key,
  output logic                          pkt_strobe,
  output logic                          pkt_hbkt_err,
  output logic                          pkt_hbkt_hit_miss,
  output logic [VT_AWIDTH-1:0]          val_ptr,
  output logic [KEY_LEN-1:0]            key_orig,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [VT_AWIDTH-1:0]          host_addr,
  input  logic [KEY_LEN-1:0]            host_wdata,
  output logic                          host_gnt,
  output logic                          host_rdata_vld,
  output logic [KEY_LEN-1:0]            host_rdata,
  output logic                          vmem_en,
  output logic                          vmem_we,
  output logic [VT_AWIDTH-1:0]          vmem_addr,
  output logic [KEY_LEN-1:0]            vmem_din,
  input  logic [KEY_LEN-1:0]            val_mem_dout_q
);

  class_vmem_arb_state_e         state_q;
  logic [1:0]                    slot_q;
  logic [1:0]                    slot_nxt;
  logic                          err_q;
  logic [NUM_CAND-1:0]           mask_q;
  logic [NUM_CAND*VT_AWIDTH-1:0] ptr_q;
  logic [KEY_LEN-1:0]            key_q;
  logic [VT_AWIDTH-1:0]          ptr_nxt;
  logic                          at_boundary;
  logic                          lk_acc;
  logic                          host_force;
  logic                          rd_issue;

`ifdef CLASS_VMEM_ARB_HOST_FAIRNESS_EN
  localparam logic [7:0] MaxWait = 8'(HOST_MAX_WAIT);

  logic [7:0] wait_q;

  always_ff @(posedge clk) begin
    if (rst || host_gnt) begin
      wait_q <= '0;
    end else if (host_req && (wait_q != 8'hff)) begin
      wait_q <= wait_q + 8'd1;
    end
  end

  assign host_force = (wait_q >= MaxWait);
`else
  logic unused_host_max_wait;
  assign unused_host_max_wait = ^HOST_MAX_WAIT;
  assign host_force           = 1'b0;
`endif

  assign slot_nxt    = slot_q + 2'd1;
  assign ptr_nxt     = ptr_q[32'(slot_nxt) * VT_AWIDTH +: VT_AWIDTH];
  assign at_boundary = (state_q == StIdle) || ((state_q == StLkup) && (slot_q == 2'd3));
  assign lk_rdy      = !rst && at_boundary && !host_force;
  assign lk_acc      = lk_vld && lk_rdy;
  assign key_orig    = key_q;
  assign rd_issue    = host_gnt && !vmem_we;

  // Outputs are registered alongside the state so each slot's sideband lines up with vmem_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      slot_q            <= '0;
      err_q             <= 1'b0;
      mask_q            <= '0;
      ptr_q             <= '0;
      key_q             <= '0;
      pkt_strobe        <= 1'b0;
      pkt_hbkt_err      <= 1'b0;
      pkt_hbkt_hit_miss <= 1'b0;
      val_ptr           <= '0;
      host_gnt          <= 1'b0;
      vmem_en           <= 1'b0;
      vmem_we           <= 1'b0;
      vmem_addr         <= '0;
      vmem_din          <= '0;
    end else begin
      pkt_strobe        <= 1'b0;
      pkt_hbkt_err      <= 1'b0;
      pkt_hbkt_hit_miss <= 1'b0;
      host_gnt          <= 1'b0;
      vmem_en           <= 1'b0;
      vmem_we           <= 1'b0;
      if (at_boundary) begin
        if (lk_acc) begin
          state_q           <= StLkup;
          slot_q            <= 2'd0;
          err_q             <= lk_err;
          mask_q            <= lk_hit_mask;
          ptr_q             <= lk_ptr;
          key_q             <= lk_key;
          pkt_strobe        <= 1'b1;
          pkt_hbkt_err      <= lk_err;
          pkt_hbkt_hit_miss <= lk_hit_mask[0];
          val_ptr           <= lk_ptr[VT_AWIDTH-1:0];
          vmem_en           <= lk_hit_mask[0] && !lk_err;
          vmem_addr         <= lk_ptr[VT_AWIDTH-1:0];
        end else if (host_req) begin
          state_q   <= StHost;
          host_gnt  <= 1'b1;
          vmem_en   <= 1'b1;
          vmem_we   <= host_we;
          vmem_addr <= host_addr;
          vmem_din  <= host_wdata;
        end else begin
          state_q <= StIdle;
        end
      end else if (state_q == StLkup) begin
        slot_q            <= slot_nxt;
        pkt_hbkt_err      <= err_q;
        pkt_hbkt_hit_miss <= mask_q[slot_nxt];
        val_ptr           <= ptr_nxt;
        vmem_en           <= mask_q[slot_nxt] && !err_q;
        vmem_addr         <= ptr_nxt;
      end else begin
        state_q <= StIdle;
      end
    end
  end

  class_vmem_rd_ret #(
    .KEY_LEN(KEY_LEN),
    .RD_LAT (RD_LAT)
  ) u_rd_ret (
    .clk           (clk),
    .rst           (rst),
    .rd_issue      (rd_issue),
    .val_mem_dout_q(val_mem_dout_q),
    .host_rdata_vld(host_rdata_vld),
    .host_rdata    (host_rdata)
  );

endmodule
